// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480 @ 25 MHz timing for the VGA timing generator.
package vga_timing_pkg;

  // Phase of one axis within its line (horizontal) or frame (vertical).
  typedef enum logic [1:0] {
    PhActive,
    PhFront,
    PhSync,
    PhBack
  } phase_e;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFront  = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBack   = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFront  = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBack   = 33;

  // Length of one axis period.
  function automatic int unsigned axis_total(int unsigned active, int unsigned front,
                                             int unsigned sync, int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter, phase FSM and registered sync level.
// Zero-length porches are skipped by the phase transitions.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DefHActive,
  parameter int unsigned FRONT  = DefHFront,
  parameter int unsigned SYNC   = DefHSync,
  parameter int unsigned BACK   = DefHBack,
  parameter bit          POL    = 1'b0
) (
  input  logic                                                     i_Clk,
  input  logic                                                     i_Reset,
  input  logic                                                     i_Step,
  output logic [$clog2(axis_total(ACTIVE, FRONT, SYNC, BACK))-1:0] count,
  output phase_e                                                   phase,
  output phase_e                                                   phase_next,
  output logic                                                     sync,
  output logic                                                     wrap
);

  localparam int unsigned Total     = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam int unsigned W         = $clog2(Total);
  localparam int unsigned SyncStart = ACTIVE + FRONT;
  localparam int unsigned SyncEnd   = SyncStart + SYNC;
  localparam logic [W-1:0] Last     = W'(Total - 1);

  logic [W-1:0] count_q, count_d;
  phase_e       phase_q, phase_d;
  logic         sync_q;
  logic         at_last;

  assign at_last = (count_q == Last);
  assign wrap    = i_Step && at_last;

  // Next position and phase; phase moves when the next count lands on a boundary.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (i_Step) begin
      count_d = at_last ? '0 : count_q + 1'b1;
      unique case (phase_q)
        PhActive: if (32'(count_d) == ACTIVE) phase_d = (FRONT != 0) ? PhFront : PhSync;
        PhFront:  if (32'(count_d) == SyncStart) phase_d = PhSync;
        // With BACK == 0 the count wraps straight out of sync into active.
        PhSync: begin
          if (32'(count_d) == SyncEnd) phase_d = PhBack;
          else if (count_d == '0)      phase_d = PhActive;
        end
        PhBack:   if (count_d == '0) phase_d = PhActive;
        default:  phase_d = PhBack;
      endcase
    end
  end

  // State registers; sync is registered from the next phase so it tracks the count.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      count_q <= Last;
      phase_q <= PhBack;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      sync_q  <= (phase_d == PhSync) ? POL : ~POL;
    end
  end

  assign count      = count_q;
  assign phase      = phase_q;
  assign phase_next = phase_d;
  assign sync       = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters plus registered
// active / line-start / frame-start flags, all describing the same position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FRONT  = DefHFront,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BACK   = DefHBack,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FRONT  = DefVFront,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BACK   = DefVBack,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  logic                                                        i_Clk,
  input  logic                                                        i_Reset,
  input  logic                                                        i_Enable,
  output logic                                                        o_HSync,
  output logic                                                        o_VSync,
  output logic                                                        o_Active,
  output logic                                                        o_Line_Start,
  output logic                                                        o_Frame_Start,
  output logic [$clog2(axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK))-1:0] o_Col_Count,
  output logic [$clog2(axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK))-1:0] o_Row_Count
);

  phase_e h_phase, h_phase_next, v_phase, v_phase_next;
  logic   h_sync, v_sync, h_wrap, v_wrap;
  logic   active_d, active_q, line_start_q, frame_start_q;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT),
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .POL    (H_POL)
  ) u_h_axis (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Step     (i_Enable),
    .count      (o_Col_Count),
    .phase      (h_phase),
    .phase_next (h_phase_next),
    .sync       (h_sync),
    .wrap       (h_wrap)
  );

  // Rows advance only on the column wrap.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT),
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .POL    (V_POL)
  ) u_v_axis (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Step     (h_wrap),
    .count      (o_Row_Count),
    .phase      (v_phase),
    .phase_next (v_phase_next),
    .sync       (v_sync),
    .wrap       (v_wrap)
  );

  // Visible when both axes will be in their active phase after this edge.
  always_comb begin
    active_d = (h_phase == PhActive) && (v_phase == PhActive);
    if (i_Enable) active_d = (h_phase_next == PhActive) && (v_phase_next == PhActive);
  end

  // Flag registers; start pulses only on an advancing edge that wraps.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      active_q      <= active_d;
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap && v_wrap;
    end
  end

  assign o_HSync       = h_sync;
  assign o_VSync       = v_sync;
  assign o_Active      = active_q;
  assign o_Line_Start  = line_start_q;
  assign o_Frame_Start = frame_start_q;

endmodule
